// File: rtl/serial_tx_gen.sv
// Multi-channel serial transmitter: lead level, nbits data bits per line in
// lock-step (MSB or LSB first), trail level, with a start/busy/done handshake.
module serial_tx_gen #(
    parameter int unsigned P_WIDTH  = 256,
    parameter int unsigned P_NCH    = 1,
    parameter int unsigned P_CW     = 32,
    parameter logic        P_Y_INIT = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [P_NCH*P_WIDTH-1:0] data,
    input  logic [15:0]              nbits,
    input  logic                     lsb_first,
    input  logic                     y0,
    input  logic [P_CW-1:0]          n0,
    input  logic [P_CW-1:0]          n1,
    input  logic [P_CW-1:0]          n2,
    output logic                     busy,
    output logic                     done,
    output logic [P_NCH-1:0]         y
);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_BIT, S_TRAIL} state_e;

    localparam logic [P_CW-1:0] CNT_ONE = P_CW'(1);

    state_e                     state_q, state_d;
    logic [P_CW-1:0]            cnt_q;
    logic [15:0]                idx_q;
    logic [P_NCH*P_WIDTH-1:0]   data_q;
    logic [15:0]                nbits_q;
    logic                       lsb_q;
    logic                       y0_q;
    logic [P_CW-1:0]            n0_q, n1_q, n2_q;
    logic [P_NCH-1:0]           y_q, y_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic                       accept;
    logic                       phase_end;
    logic                       last_bit;
    logic [15:0]                nbits_clamp;
    logic [15:0]                next_pos;
    logic [15:0]                word_idx;
    logic [P_NCH-1:0]           next_bits;

    assign accept   = (state_q == S_IDLE) && start;
    assign last_bit = (idx_q == nbits_q - 16'd1);

    always_comb begin
        nbits_clamp = nbits;
        if (nbits == 16'd0) begin
            nbits_clamp = 16'd1;
        end else if (32'(nbits) > P_WIDTH) begin
            nbits_clamp = 16'(P_WIDTH);
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        phase_end = 1'b0;
        unique case (state_q)
            S_LEAD:  phase_end = (cnt_q == n0_q - CNT_ONE);
            S_BIT:   phase_end = (cnt_q == n1_q - CNT_ONE);
            S_TRAIL: phase_end = (cnt_q == n2_q - CNT_ONE);
            default: phase_end = 1'b0;
        endcase
    end

    // Word bit driven after the next edge: position 0 when leaving LEAD, else the following bit.
    always_comb begin
        logic [P_WIDTH-1:0] word;
        word      = '0;
        next_bits = '0;
        next_pos  = (state_q == S_LEAD) ? 16'd0 : idx_q + 16'd1;
        word_idx  = lsb_q ? next_pos : nbits_q - 16'd1 - next_pos;
        for (int c = 0; c < int'(P_NCH); c++) begin
            word         = data_q[c*P_WIDTH +: P_WIDTH] >> word_idx;
            next_bits[c] = word[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_LEAD;
            S_LEAD:  if (phase_end) state_d = S_BIT;
            S_BIT:   if (phase_end && last_bit) state_d = S_TRAIL;
            S_TRAIL: if (phase_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        y_d    = y_q;
        busy_d = busy_q;
        done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                y_d    = {P_NCH{y0}};
                busy_d = start;
            end
            S_LEAD: begin
                busy_d = 1'b1;
                y_d    = phase_end ? next_bits : {P_NCH{y0_q}};
            end
            S_BIT: begin
                busy_d = 1'b1;
                if (phase_end) begin
                    y_d = last_bit ? {P_NCH{y0_q}} : next_bits;
                end
            end
            S_TRAIL: begin
                if (phase_end) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    y_d    = {P_NCH{y0}};
                end else begin
                    busy_d = 1'b1;
                    y_d    = {P_NCH{y0_q}};
                end
            end
            default: begin
                y_d    = {P_NCH{y0}};
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            y_q    <= {P_NCH{P_Y_INIT}};
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            busy_q <= busy_d;
            done_q <= done_d;
            if (state_q == S_IDLE || phase_end) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (state_q == S_LEAD) begin
                idx_q <= '0;
            end else if (state_q == S_BIT && phase_end) begin
                idx_q <= idx_q + 16'd1;
            end
        end
    end

    // NOTE: the transfer settings are plain data registers; they are only read after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q  <= data;
            nbits_q <= nbits_clamp;
            lsb_q   <= lsb_first;
            y0_q    <= y0;
            n0_q    <= (n0 == '0) ? CNT_ONE : n0;
            n1_q    <= (n1 == '0) ? CNT_ONE : n1;
            n2_q    <= (n2 == '0) ? CNT_ONE : n2;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;

endmodule

// File: tb/tb_serial_tx_gen.sv
// Self-checking bench for serial_tx_gen: directed scenarios plus random transfers
// compared against an expected-waveform queue built from the transfer rules.
module tb_serial_tx_gen;

    localparam int   W   = 16;
    localparam int   NCH = 4;
    localparam int   CW  = 8;
    localparam logic YI  = 1'b1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [NCH*W-1:0]   data;
    logic [15:0]        nbits;
    logic               lsb_first;
    logic               y0;
    logic [CW-1:0]      n0, n1, n2;
    logic               busy;
    logic               done;
    logic [NCH-1:0]     y;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_tx_gen #(
        .P_WIDTH  (W),
        .P_NCH    (NCH),
        .P_CW     (CW),
        .P_Y_INIT (YI)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data      (data),
        .nbits     (nbits),
        .lsb_first (lsb_first),
        .y0        (y0),
        .n0        (n0),
        .n1        (n1),
        .n2        (n2),
        .busy      (busy),
        .done      (done),
        .y         (y)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        data      = {$urandom, $urandom};
        nbits     = 16'($urandom);
        lsb_first = 1'($urandom);
        y0        = 1'($urandom);
        n0        = CW'($urandom);
        n1        = CW'($urandom);
        n2        = CW'($urandom);
    endtask

    // Expected waveform: lead level, each bit held n1 cycles, trail level, then done.
    task automatic run_xfer(input logic [NCH*W-1:0] d, input int nb, input logic lsb,
                            input logic yl, input int a0, input int a1, input int a2,
                            input bit hold_start, input int poke_at);
        logic [NCH-1:0]   exp_q[$];
        logic [NCH-1:0]   v;
        logic [NCH*W-1:0] sh;
        int nbc, d0, d1, d2, bi;
        nbc = (nb == 0) ? 1 : ((nb > W) ? W : nb);
        d0  = (a0 == 0) ? 1 : a0;
        d1  = (a1 == 0) ? 1 : a1;
        d2  = (a2 == 0) ? 1 : a2;
        repeat (d0) exp_q.push_back({NCH{yl}});
        for (int i = 0; i < nbc; i++) begin
            bi = lsb ? i : nbc - 1 - i;
            for (int c = 0; c < NCH; c++) begin
                sh   = d >> (c * W + bi);
                v[c] = sh[0];
            end
            repeat (d1) exp_q.push_back(v);
        end
        repeat (d2) exp_q.push_back({NCH{yl}});

        @(negedge clk);
        data      = d;
        nbits     = 16'(nb);
        lsb_first = lsb;
        y0        = yl;
        n0        = CW'(a0);
        n1        = CW'(a1);
        n2        = CW'(a2);
        start     = 1'b1;
        @(posedge clk);
        foreach (exp_q[t]) begin
            #1;
            check("y", 32'(y), 32'(exp_q[t]));
            check("busy", 32'(busy), 32'd1);
            check("done_low", 32'(done), 32'd0);
            @(negedge clk);
            scramble_inputs();
            start = hold_start || (t == poke_at);
            @(posedge clk);
        end
        #1;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("y_end", 32'(y), 32'({NCH{y0}}));
        if (!hold_start) begin
            @(negedge clk);
            start = 1'b0;
            y0    = 1'($urandom);
            @(posedge clk);
            #1;
            check("done_once", 32'(done), 32'd0);
            check("busy_idle", 32'(busy), 32'd0);
            check("y_idle", 32'(y), 32'({NCH{y0}}));
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        data      = '0;
        nbits     = '0;
        lsb_first = 1'b0;
        y0        = 1'b0;
        n0        = '0;
        n1        = '0;
        n2        = '0;
        #1;
        check("rst_y", 32'(y), 32'({NCH{YI}}));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // IDLE: y follows live y0
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            y0 = 1'(i);
            @(posedge clk);
            #1;
            check("idle_y", 32'(y), 32'({NCH{y0}}));
        end

        run_xfer(64'h00A5, 8, 1'b0, 1'b0, 3, 2, 4, 1'b0, -1);
        run_xfer(64'h00A5, 8, 1'b1, 1'b0, 3, 2, 4, 1'b0, -1);
        run_xfer(64'h0001, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0, -1);
        run_xfer({16'h8, 16'h4, 16'h2, 16'h1}, 4, 1'b0, 1'b0, 1, 1, 1, 1'b0, -1);
        run_xfer({16'h8, 16'h4, 16'h2, 16'h1}, 4, 1'b1, 1'b1, 2, 2, 1, 1'b0, -1);
        // start pulsed during bit 2, then start held through done into a second transfer
        run_xfer({$urandom, $urandom}, 6, 1'b0, 1'b1, 2, 3, 2, 1'b0, 2 + 2 * 3 - 1);
        run_xfer({$urandom, $urandom}, 5, 1'b1, 1'b0, 1, 2, 3, 1'b1, -1);
        run_xfer({$urandom, $urandom}, 20, 1'b0, 1'b1, 2, 1, 2, 1'b0, -1);

        // asynchronous reset in the middle of BIT
        @(negedge clk);
        data      = '0;
        nbits     = 16'd8;
        lsb_first = 1'b0;
        y0        = 1'b0;
        n0        = CW'(2);
        n1        = CW'(3);
        n2        = CW'(2);
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_y", 32'(y), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_y", 32'(y), 32'({NCH{YI}}));
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        y0  = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_y", 32'(y), 32'd0);
        end

        for (int r = 0; r < 30; r++) begin
            run_xfer({$urandom, $urandom}, int'($urandom_range(0, W + 3)), 1'($urandom),
                     1'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 4)), (r < 29) && ($urandom_range(0, 3) == 0), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_tx_gen.md
# serial_tx_gen

Parametrised multi-channel serial transmitter, the next generation of our single-channel MSB-first shifter. It sends up to `P_NCH` words in lock-step, one per output line, with configurable word length, bit order and lead/bit/trail durations. It runs from an internal cycle counter and a start/busy/done handshake instead of an external timebase. It sits between the register bank and the pad drivers of serial control links such as DAC loads and ASIC configuration chains.

## Interface
Parameters:
- `P_WIDTH`, 256: maximum word length in bits, minimum 1
- `P_NCH`, 1: number of parallel output channels, minimum 1
- `P_CW`, 32: width of the duration inputs and the internal counter
- `P_Y_INIT`, 0: reset value of every `y` bit

Ports:
- `clk`  in  1  clock; one clock domain; every event happens on its rising edge
- `rst`  in  1  reset: asynchronous, active-high
- `start`  in  1  request a transfer; accepted only while `busy`=0
- `data`  in  `P_NCH*P_WIDTH`  channel c word is `data[c*P_WIDTH +: P_WIDTH]`
- `nbits`  in  16  number of bits to send
- `lsb_first`  in  1  0 = MSB first (bit nbits-1 down to 0), 1 = LSB first (bit 0 up to nbits-1)
- `y0`  in  1  idle/lead/trail output level
- `n0`  in  `P_CW`  lead duration in cycles
- `n1`  in  `P_CW`  cycles per bit
- `n2`  in  `P_CW`  trail duration in cycles
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle pulse when a transfer ends
- `y`  out  `P_NCH`  serial outputs

## Operation
- On reset: `y`={P_NCH{P_Y_INIT}}, `busy`=0, `done`=0, state IDLE, counter 0. Reset in the middle of a transfer aborts it. Nothing resumes after reset.
- The block has four states: IDLE, LEAD, BIT, TRAIL.
- In IDLE, `y` follows the live `y0` on every line.
- `start`=1 in IDLE at edge k:
  - Latches `data`, `lsb_first` and `y0`.
  - Latches `nbits` clamped: 0 becomes 1, and values above `P_WIDTH` become `P_WIDTH`.
  - Latches `n0`, `n1` and `n2`, each forced to 1 when 0.
  - Sets `busy`=1 and goes to LEAD.
  - Later changes to any input have no effect until the next accept.
- LEAD: all lines drive the latched `y0` for n0 cycles, then the state goes to BIT.
- BIT: all lines present bit index b of their own word, each bit held for n1 cycles.
  - Index sequence is nbits-1 down to 0 (MSB first) or 0 up to nbits-1 (LSB first).
  - Word bits at index nbits and above are ignored.
  - After nbits bits, the state goes to TRAIL.
- TRAIL: all lines drive the latched `y0` for n2 cycles. The block then pulses `done`, clears `busy` and returns to IDLE.
- `start` while `busy`=1 is ignored and is not queued.
- Internal counter: counts 0 to (duration-1) in each phase and in each bit, then reloads at 0. Width is `P_CW`. The counter never wraps, because every duration is at most 2^P_CW-1.
- Bit index counter: 16-bit, compared against the latched, clamped nbits.

## Timing
Take `start` sampled high at edge k, with values after clamping.
- Edge k: `busy` rises. `y` = latched y0.
- First data bit drives `y` from edge k+n0.
- Bit i (i = 0..nbits-1 in send order) drives `y` from edge k+n0+i*n1 to k+n0+(i+1)*n1.
- Trail starts at edge T = k+n0+nbits*n1. `y` = y0.
- Edge T+n2: `done`=1 for exactly one cycle, `busy`=0, state IDLE.
- Total busy duration is n0+nbits*n1+n2 cycles.
- Back-to-back: `start` high in the cycle where `done`=1 is accepted at the next edge. The minimum gap between transfers is therefore zero idle cycles beyond the done cycle.
- Outputs are registered, with no combinational path from inputs to `y`, `busy` or `done`.
- The behaviour of every channel is cycle-identical; only the data differs.

## Test plan
1. P_NCH=1, data=0xA5, nbits=8, n0=3, n1=2, n2=4, MSB first.
   - Required `y`: y0 for 3 cycles, then 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1.
   - Then y0 for 4 cycles, `done` at edge k+23, `busy` high for 23 cycles.
2. Same stimulus with `lsb_first`=1 -> bit order 1,0,1,0,0,1,0,1, each bit held for 2 cycles. Timing identical to scenario 1.
3. n0=n1=n2=0, nbits=0, data bit0=1.
   - Required: treated as 1/1/1/1, giving 1 lead cycle, 1 data cycle of 1, and 1 trail cycle.
   - `done` at edge k+3.
4. P_NCH=4, channels with data 0x1, 0x2, 0x4, 0x8 and nbits=4 -> one-hot pattern moves across the lines in lock-step.
   - MSB first: bit 3 of channel 3 is sent first.
5. `start` pulsed at bit 2 of a transfer -> ignored, with no change to timing. `start` held high through `done` -> a second transfer starts at the edge after `done`.
6. `rst` asserted mid-BIT -> `y`=P_Y_INIT, `busy`=0 and `done`=0 immediately, without waiting for a clock edge. After release with `start` low, the block stays IDLE with `y` following `y0`.
